// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit living in the EX stage.
// A 32-step shift-add multiply or restoring divide runs on operand magnitudes,
// with the sign applied once at the end. The pipeline is stalled while busy.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_funct3,
  input  logic [6:0]  ex_funct7,
  input  logic [31:0] ex_reg1,
  input  logic [31:0] ex_reg2,
  output logic        stallreq_md,
  output logic        md_done,
  output logic [31:0] md_result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    neg64 = ~v + 64'd1;
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] r_b;        // multiplicand (mul) or divisor (div) magnitude
  logic [2:0]  r_op;
  logic        r_neg_res;  // negate product / quotient at the end
  logic        r_neg_rem;  // remainder follows a negative dividend
  logic [5:0]  r_cnt;
  logic [31:0] r_result;

  logic        w_is_mop;
  logic        w_start;
  logic        w_rs1_signed;
  logic        w_rs2_signed;
  logic        w_neg1;
  logic        w_neg2;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_special;
  logic [31:0] w_special_result;
  logic [32:0] w_sum;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_step;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_calc_result;

  assign w_is_mop = (ex_opcode == OPC_OP) && (ex_funct7 == F7_MULDIV);
  assign w_start  = w_is_mop && (r_state == ST_IDLE);

  // MULH/MULHSU/DIV/REM read rs1 as signed; MULH/DIV/REM read rs2 as signed.
  assign w_rs1_signed = (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                        (ex_funct3 == 3'b100) || (ex_funct3 == 3'b110);
  assign w_rs2_signed = (ex_funct3 == 3'b001) || (ex_funct3 == 3'b100) ||
                        (ex_funct3 == 3'b110);
  assign w_neg1 = w_rs1_signed && ex_reg1[31];
  assign w_neg2 = w_rs2_signed && ex_reg2[31];
  assign w_mag1 = w_neg1 ? neg32(ex_reg1) : ex_reg1;
  assign w_mag2 = w_neg2 ? neg32(ex_reg2) : ex_reg2;

  // Divide cases that bypass the iteration entirely.
  assign w_div_zero = ex_funct3[2] && (ex_reg2 == 32'h0);
  assign w_div_ovf  = ex_funct3[2] && !ex_funct3[0] &&
                      (ex_reg1 == 32'h80000000) && (ex_reg2 == 32'hFFFFFFFF);
  assign w_special  = w_div_zero || w_div_ovf;
  assign w_special_result = w_div_zero ? (ex_funct3[1] ? ex_reg1 : 32'hFFFFFFFF)
                                       : (ex_funct3[1] ? 32'h0 : 32'h80000000);

  // One iteration of the shift-add multiply or restoring divide.
  always_comb begin
    w_sum    = {1'b0, r_acc[63:32]} + {1'b0, r_b};
    w_rem_sh = r_acc[63:31];
    w_ge     = (w_rem_sh >= {1'b0, r_b});
    w_diff   = w_rem_sh[31:0] - r_b;
    if (r_op[2]) begin
      w_step = {(w_ge ? w_diff : w_rem_sh[31:0]), r_acc[30:0], w_ge};
    end else if (r_acc[0]) begin
      w_step = {w_sum, r_acc[31:1]};
    end else begin
      w_step = {1'b0, r_acc[63:1]};
    end
  end

  // Sign fix-up and result selection applied to the final iteration.
  always_comb begin
    w_prod = r_neg_res ? neg64(w_step) : w_step;
    w_quot = r_neg_res ? neg32(w_step[31:0]) : w_step[31:0];
    w_rem  = r_neg_rem ? neg32(w_step[63:32]) : w_step[63:32];
    case (r_op)
      3'b000:                 w_calc_result = w_prod[31:0];
      3'b001, 3'b010, 3'b011: w_calc_result = w_prod[63:32];
      3'b100, 3'b101:         w_calc_result = w_quot;
      3'b110, 3'b111:         w_calc_result = w_rem;
      default:                w_calc_result = 32'h0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; DONE always returns to IDLE without restarting.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = w_special ? ST_DONE : ST_CALC;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (r_cnt == 6'd31) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_CALC;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: stall combinationally from the start cycle through CALC.
  always_comb begin
    stallreq_md = 1'b0;
    md_done     = 1'b0;
    md_result   = r_result;
    case (r_state)
      ST_IDLE: stallreq_md = w_start;
      ST_CALC: stallreq_md = 1'b1;
      ST_DONE: md_done     = 1'b1;
      default: stallreq_md = 1'b0;
    endcase
  end

  // Datapath: latch operands on start, iterate in CALC, capture the result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc     <= 64'h0;
      r_b       <= 32'h0;
      r_op      <= 3'b000;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= 6'd0;
      r_result  <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_op      <= ex_funct3;
            r_neg_res <= w_neg1 ^ w_neg2;
            r_neg_rem <= w_neg1;
            r_cnt     <= 6'd0;
            r_b       <= ex_funct3[2] ? w_mag2 : w_mag1;
            r_acc     <= {32'h0, (ex_funct3[2] ? w_mag1 : w_mag2)};
            if (w_special) begin
              r_result <= w_special_result;
            end
          end
        end
        ST_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_result <= w_calc_result;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vector table, hand-written timing sequences and
// randomized ops checked against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic        stallreq_md;
  logic        md_done;
  logic [31:0] md_result;

  int n_tests = 0;
  int n_fail  = 0;

  ex_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .ex_opcode  (ex_opcode),
    .ex_funct3  (ex_funct3),
    .ex_funct7  (ex_funct7),
    .ex_reg1    (ex_reg1),
    .ex_reg2    (ex_reg2),
    .stallreq_md(stallreq_md),
    .md_done    (md_done),
    .md_result  (md_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stalls;
    string       name;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int stalls, input string name);
    vecs[i].f3     = f3;
    vecs[i].a      = a;
    vecs[i].b      = b;
    vecs[i].exp    = exp;
    vecs[i].stalls = stalls;
    vecs[i].name   = name;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    ex_opcode = opc;
    ex_funct7 = f7;
    ex_funct3 = f3;
    ex_reg1   = a;
    ex_reg2   = b;
  endtask

  task automatic drive_bubble();
    drive(7'h0, 7'h0, 3'h0, 32'h0, 32'h0);
  endtask

  // Reference model: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = 64'h0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'h0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_stalls(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    if (f3[2] && (b == 32'h0)) return 1;
    if (f3[2] && !f3[0] && (a == 32'h80000000) && (b == 32'hFFFFFFFF)) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Issue one M-op at posedge+1 and follow it to its md_done pulse.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int stalls, input string name);
    int n_stall;
    int n_gap;
    bit got;
    drive(7'b0110011, 7'b0000001, f3, a, b);
    n_stall = 0;
    n_gap   = 0;
    got     = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (md_done) begin
        got = 1'b1;
        check({name, "_result"}, md_result, exp);
        check({name, "_stall_in_done"}, {31'h0, stallreq_md}, 32'h0);
      end else if (stallreq_md) begin
        n_stall++;
      end else begin
        n_gap++;
      end
      @(posedge clk);
      #1;
      if (got) break;
    end
    check({name, "_done_seen"}, {31'h0, got}, 32'h1);
    check({name, "_stall_cycles"}, 32'(n_stall), 32'(stalls));
    check({name, "_idle_gap"}, 32'(n_gap), 32'h0);
  endtask

  // Checks that the unit stays quiet for a number of cycles.
  task automatic expect_idle(input int cycles, input string name);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check({name, "_stall"}, {31'h0, stallreq_md}, 32'h0);
      check({name, "_done"}, {31'h0, md_done}, 32'h0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;

    set_vec(0,  3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7_m3");
    set_vec(1,  3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min_min");
    set_vec(2,  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max_max");
    set_vec(3,  3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, "mulhsu_m1_2");
    set_vec(4,  3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_m7_2");
    set_vec(5,  3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_m7_2");
    set_vec(6,  3'd5, 32'd100,      32'd7,        32'd14,       33, "divu_100_7");
    set_vec(7,  3'd7, 32'd100,      32'd7,        32'd2,        33, "remu_100_7");
    set_vec(8,  3'd5, 32'd100,      32'd0,        32'hFFFFFFFF, 1,  "divu_by0");
    set_vec(9,  3'd6, 32'd100,      32'd0,        32'd100,      1,  "rem_by0");
    set_vec(10, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf");
    set_vec(11, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1,  "rem_ovf");
    set_vec(12, 3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, "div_7_m2");
    set_vec(13, 3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33, "rem_7_m2");
    set_vec(14, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        33, "mulh_m1_m1");
    set_vec(15, 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, "mulhsu_min_max");
    set_vec(16, 3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h0,        33, "divu_min_max");
    set_vec(17, 3'd4, 32'h80000000, 32'd1,        32'h80000000, 33, "div_min_1");
    set_vec(18, 3'd7, 32'd5,        32'd0,        32'd5,        1,  "remu_by0");

    // Reset state with the bubble on the ID/EX inputs.
    rst = 1'b0;
    drive_bubble();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {31'h0, stallreq_md}, 32'h0);
    check("reset_done", {31'h0, md_done}, 32'h0);
    check("reset_result", md_result, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Non-M instructions never stall.
    drive(7'b0110011, 7'b0000000, 3'b000, 32'd5, 32'd6);
    expect_idle(3, "add");
    drive(7'b0010011, 7'b0000001, 3'b000, 32'd5, 32'd6);
    expect_idle(2, "addi_f7");
    drive_bubble();
    expect_idle(2, "bubble");

    // Directed vector table, issued back to back.
    for (int i = 0; i < 19; i++) begin
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stalls, vecs[i].name);
    end
    drive_bubble();
    expect_idle(2, "after_table");

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      do_op(f3, a, b, ref_model(f3, a, b), ref_stalls(f3, a, b), $sformatf("rnd%0d_f%0d", i, f3));
      if ($urandom_range(0, 1) == 1) begin
        drive_bubble();
        expect_idle(1, "rnd_gap");
      end
    end
    drive_bubble();
    expect_idle(1, "after_rnd");

    // Back-to-back MUL 3x4 then DIVU 12/5: done on T33 and T67.
    do_op(3'd0, 32'd3, 32'd12 / 32'd3, 32'd12, 33, "b2b_mul");
    do_op(3'd5, 32'd12, 32'd5, 32'd2, 33, "b2b_divu");
    drive_bubble();
    expect_idle(2, "after_b2b");

    // Reset in the middle of a MUL aborts it.
    drive(7'b0110011, 7'b0000001, 3'd0, 32'd123, 32'd456);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("midrst_stall_T%0d", c), {31'h0, stallreq_md}, 32'h1);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    drive_bubble();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_T11_stall", {31'h0, stallreq_md}, 32'h0);
    check("midrst_T11_done", {31'h0, md_done}, 32'h0);
    check("midrst_T11_result", md_result, 32'h0);
    @(posedge clk);
    #1;
    expect_idle(40, "midrst_quiet");
    do_op(3'd5, 32'd9, 32'd3, 32'd3, 33, "post_rst_divu");
    drive_bubble();
    expect_idle(2, "final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, alongside the single-cycle ALU. It consumes the opcode, funct and operand fields registered by the ID/EX pipeline register, and runs a 32-step shift-add multiply or restoring divide. While it runs it asserts a stall request that freezes IF/ID/EX. It returns a 32-bit result, which the EX stage muxes onto its write-back data.

## Interface
- No parameters; widths are fixed to RV32.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- ex_opcode  in  7  opcode from ID/EX.
- ex_funct3  in  3  funct3 from ID/EX.
- ex_funct7  in  7  funct7 from ID/EX.
- ex_reg1  in  32  rs1 operand (dividend / multiplicand).
- ex_reg2  in  32  rs2 operand (divisor / multiplier).
- stallreq_md  out  1  stall request to the stall controller; freezes ID/EX so inputs stay stable.
- md_done  out  1  one-cycle pulse; md_result is valid this cycle.
- md_result  out  32  result; meaningful only when md_done==1.

## Operation
- M-op detect: ex_opcode==7'b0110011 && ex_funct7==7'b0000001.
- funct3 selects the op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, CALC, DONE.
- IDLE, no M-op:
  - stallreq_md=0, md_done=0.
- IDLE, M-op detected (start):
  - stallreq_md=1 combinationally in the same cycle.
  - Latch the operand magnitudes, op and result-sign into internal registers; clear the 6-bit step counter.
  - Next state is CALC, or DONE directly for a divide special case.
- Signedness:
  - rs1 is treated as signed for MULH, MULHSU, DIV, REM.
  - rs2 is treated as signed for MULH, DIV, REM.
  - Magnitude = two's-complement negate of a negative signed operand.
- CALC, multiply:
  - Each step: if multiplier bit 0 is 1, add the multiplicand into the upper half of a 64-bit accumulator (33-bit add to keep the carry).
  - Then shift the accumulator right by 1 and the multiplier right by 1.
- CALC, divide:
  - Each step: shift {remainder, quotient} left by 1 and trial-subtract the divisor from the 33-bit remainder.
  - If there is no borrow, keep the difference and set quotient bit 0 to 1.
- CALC lasts exactly 32 cycles (counter 0..31) with stallreq_md=1, then moves to DONE.
- Sign fix-up, applied when leaving CALC:
  - Product: the 64-bit product is negated if the operand signs differ.
  - Quotient: negated if the operand signs differ (signed divide only).
  - Remainder: takes the dividend's sign.
- Result selection:
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
  - DIV and DIVU return the quotient; REM and REMU return the remainder.
- Divide special cases (skip CALC, IDLE goes straight to DONE):
  - Divisor==0: quotient = 32'hFFFFFFFF, remainder = rs1.
  - DIV/REM with rs1==32'h80000000 and rs2==32'hFFFFFFFF: quotient = 32'h80000000, remainder = 0.
- DONE:
  - stallreq_md=0, md_done=1, md_result driven from the result register.
  - Next state is always IDLE. DONE never starts a new op, even though ID/EX still holds the same M-op this cycle.
- The ID/EX bubble (all zero) is not an M-op, so it never triggers a start.

## Timing
- Reset (rst==0 at an edge): state=IDLE, counter=0, result register=0.
- Reset values of outputs: stallreq_md=0, md_done=0, md_result=32'h0.
- Reset during CALC aborts the operation. The cycle after reset, stallreq_md=0 and no md_done pulse occurs.
- Normal op, with the start cycle as T0:
  - stallreq_md=1 on T0..T32.
  - DONE on T33: md_done=1 and stallreq_md=0.
  - ID/EX loads the next instruction at the end of T33.
  - Total: 33 stall cycles.
- Special-case divide: stallreq_md=1 on T0 only, DONE on T1 (1 stall cycle).
- Back-to-back M-ops: the second op starts in the cycle after DONE. There is no dead cycle beyond DONE.
- md_result is held stable through DONE; its value outside DONE is don't-care.

## Test plan
- MUL: rs1=7, rs2=32'hFFFFFFFD -> 33 stall cycles, then md_done with md_result=32'hFFFFFFEB.
- MULH 32'h80000000 x 32'h80000000 -> 32'h40000000.
- MULHU 32'hFFFFFFFF x 32'hFFFFFFFF -> 32'hFFFFFFFE.
- MULHSU 32'hFFFFFFFF x 2 -> 32'hFFFFFFFF.
- DIV: rs1=-7, rs2=2 -> 32'hFFFFFFFD.
- REM: rs1=-7, rs2=2 -> 32'hFFFFFFFF.
- DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with exactly 1 stall cycle:
  - DIVU 100/0 -> 32'hFFFFFFFF; REM 100/0 -> 100.
  - DIV 32'h80000000/32'hFFFFFFFF -> 32'h80000000; REM with the same operands -> 0.
- Reset mid-op: start MUL, drive rst=0 at T10 -> T11 shows stallreq_md=0, md_done=0, md_result=0; no later md_done. A DIVU 9/3 issued after reset is released returns 3.
- Back-to-back MUL 3x4 then DIVU 12/5:
  - md_done pulses for 12 on T33 and for 2 on T67.
  - stallreq_md is 0 only on T33 between the two ops.
  - Non-M instructions (ADD, bubble) keep stallreq_md=0 throughout.
